// File: rtl/fp_sched_pkg.sv
// fp_sched_pkg: op, FSM state and result-tag types shared by the FP unit scheduler
package fp_sched_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_MUL = 2'd1, OP_DIV = 2'd2, OP_EXP = 2'd3} fp_op_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2} sched_state_e;
  typedef struct packed {
    logic       v;
    logic [2:0] idx;
  } tag_t;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
endpackage

// File: rtl/fp_unit_scheduler_if.sv
// fp_unit_scheduler_if: requester, FU and response signals of the FP unit scheduler
interface fp_unit_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a, req_b;
  logic                      fu_valid;
  logic [1:0]                fu_op;
  logic [DATA_W-1:0]         fu_a, fu_b, fu_z, rsp_data;
  modport master (
    output req_valid, req_op, req_a, req_b, fu_z,
    input  req_ready, fu_valid, fu_op, fu_a, fu_b, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, fu_z,
    output req_ready, fu_valid, fu_op, fu_a, fu_b, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or after ptr, wrapping mod N
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    // scan farthest-first so the request nearest ptr overwrites the rest
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/fp_unit_scheduler.sv
// fp_unit_scheduler: round-robin sharing of one fixed-latency FP unit,
// results routed back to the issuer through a tag pipe aligned with the FU latency.
module fp_unit_scheduler
  import fp_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  parameter  int FU_LAT  = 3,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int CW      = $clog2(FU_LAT + 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_unit_scheduler_if.slave  bus,
  input  logic                flush,
  output logic                flush_done,
  output logic                busy
);
  sched_state_e       state, state_nxt;
  tag_t               tags [FU_LAT+1];
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  logic               can_grant, hs, rsp;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (bus.req_valid & {NUM_REQ{can_grant}}),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );
  assign bus.req_ready = grant;
  assign hs            = |grant;
  // the tag leaves the pipe in the same cycle its result sits on fu_z
  assign rsp           = tags[FU_LAT].v && !rst_n;
  assign bus.rsp_valid = rsp ? NUM_REQ'(1) << tags[FU_LAT].idx : '0;
  assign bus.rsp_data  = rsp ? bus.fu_z : '0;
  assign busy          = cnt != '0 && !rst_n;
  always_ff @(posedge clk)
    state <= rst_n ? S_IDLE : state_nxt;
  always_comb
    state_nxt = state == S_DRAIN ? (cnt == '0 ? S_IDLE : S_DRAIN)
              : flush ? S_DRAIN
              : hs ? S_BUSY
              : state == S_BUSY && cnt == CW'(1) && rsp ? S_IDLE
              : state;
  always_comb begin
    can_grant  = state != S_DRAIN && !flush && !rst_n;
    flush_done = state == S_DRAIN && cnt == '0 && !rst_n;
  end
  always_ff @(posedge clk)
    if (rst_n) begin
      ptr          <= '0;
      cnt          <= '0;
      tags         <= '{default: '0};
      bus.fu_valid <= 1'b0;
      bus.fu_op    <= '0;
      bus.fu_a     <= '0;
      bus.fu_b     <= '0;
    end else begin
      ptr          <= hs ? IW'((int'(gidx) + 1) % NUM_REQ) : ptr;
      cnt          <= cnt + CW'(hs) - CW'(rsp);
      tags[0]      <= {hs, 3'(gidx)};
      for (int s = 1; s <= FU_LAT; s++) tags[s] <= tags[s-1];
      bus.fu_valid <= hs;
      if (hs) begin
        bus.fu_op <= bus.req_op[2*gidx +: 2];
        bus.fu_a  <= bus.req_a[DATA_W*gidx +: DATA_W];
        bus.fu_b  <= bus.req_b[DATA_W*gidx +: DATA_W];
      end
    end
endmodule

// File: tb/tb_fp_unit_scheduler.sv
// tb_fp_unit_scheduler: directed table, corner-case sequences and randomized traffic
// checked against a queue-based model of the scheduler plus a real-arithmetic FU model.
module tb_fp_unit_scheduler;
  import fp_sched_pkg::*;
  localparam int N = 4, DW = 32, LAT = 3;
  localparam logic [31:0] ONE = 32'h3F80_0000, TWO = 32'h4000_0000, Z = 32'h0;
  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, flush_done, busy;
  int checks = 0, errors = 0;
  fp_unit_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) ifc ();
  fp_unit_scheduler #(.NUM_REQ(N), .DATA_W(DW), .FU_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );
  always #5 clk = ~clk;
  function automatic real sp2r(logic [31:0] a);
    if (a[30:0] == 31'h0) return 0.0;
    return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0});
  endfunction
  function automatic logic [31:0] r2sp(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] fu_fn(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    real x, y;
    x = sp2r(a);
    y = sp2r(b);
    return r2sp(op == OP_ADD ? x + y : op == OP_MUL ? x * y : op == OP_DIV ? x / y : $exp(x));
  endfunction
  // FU model: result appears LAT cycles after fu_valid
  logic [31:0] zp [LAT];
  always @(posedge clk) begin
    zp[0] <= ifc.fu_valid ? fu_fn(ifc.fu_op, ifc.fu_a, ifc.fu_b) : 32'h0;
    for (int s = 1; s < LAT; s++) zp[s] <= zp[s-1];
  end
  assign ifc.fu_z = zp[LAT-1];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: pending responses as a queue of {due cycle, requester, value}
  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } pend_t;
  pend_t q[$];
  int    cyc = 0, mptr = 0;
  bit    drn = 1'b0;
  always @(negedge clk) begin
    logic [3:0]  er, ev;
    logic [31:0] ed;
    int          g;
    g = -1;
    if (!rst_n && !flush && !drn)
      for (int k = 0; k < N; k++)
        if (g < 0 && ifc.req_valid[(mptr + k) % N]) g = (mptr + k) % N;
    er = g < 0 ? 4'b0 : 4'(1 << g);
    ev = 4'b0;
    ed = 32'h0;
    if (!rst_n && q.size() > 0 && q[0].due == cyc) begin
      ev = 4'(1 << q[0].idx);
      ed = q[0].data;
    end
    check("m_ready", 32'(ifc.req_ready), 32'(er));
    check("m_rsp_valid", 32'(ifc.rsp_valid), 32'(ev));
    check("m_rsp_data", ifc.rsp_data, ed);
    check("m_busy", 32'(busy), 32'(!rst_n && q.size() != 0));
    check("m_flush_done", 32'(flush_done), 32'(!rst_n && drn && q.size() == 0));
    if (rst_n) begin
      q.delete();
      mptr = 0;
      drn  = 1'b0;
    end else begin
      if (drn && q.size() == 0) drn = 1'b0;
      else if (!drn && flush) drn = 1'b1;
      if (ev != 4'b0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{cyc + LAT + 1, g,
                      fu_fn(ifc.req_op[2*g +: 2], ifc.req_a[32*g +: 32], ifc.req_b[32*g +: 32])});
        mptr = (g + 1) % N;
      end
    end
    cyc++;
  end
  task automatic drive(logic r, logic f, logic [3:0] v, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #1;
    rst_n         = r;
    flush         = f;
    ifc.req_valid = v;
    ifc.req_op    = {4{op}};
    ifc.req_a     = {4{a}};
    ifc.req_b     = {4{b}};
    @(negedge clk);
  endtask
  typedef struct {
    logic        r, f;
    logic [3:0]  v;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  rdy, rv;
    logic [31:0] d;
    logic        bsy, done;
  } vec_t;
  vec_t        tbl [19];
  logic [31:0] pool [6];
  int          npulse, nrsp;
  initial begin
    ifc.req_valid = '0;
    ifc.req_op    = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    pool = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h4040_0000, 32'hBFC0_0000, 32'h0};
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, OP_MUL, ONE, TWO, 4'b0001, 4'b0000, Z,      1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0001, TWO,    1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0010, OP_EXP, Z,   TWO, 4'b0010, 4'b0000, Z,      1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1001, OP_ADD, ONE, ONE, 4'b1000, 4'b0000, Z,      1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b1001, OP_ADD, ONE, ONE, 4'b0001, 4'b0000, Z,      1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0010, FP_ONE, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b1000, TWO,    1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0001, TWO,    1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 4'b0001, OP_ADD, ONE, TWO, 4'b0000, 4'b0000, Z,      1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 4'b0001, OP_ADD, ONE, TWO, 4'b0000, 4'b0000, Z,      1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'b0001, OP_ADD, ONE, TWO, 4'b0001, 4'b0000, Z,      1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'b0000, OP_ADD, Z,   Z,   4'b0000, 4'b0000, Z,      1'b1, 1'b0};
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("t%0d_ready", i), 32'(ifc.req_ready), 32'(tbl[i].rdy));
      check($sformatf("t%0d_rsp_valid", i), 32'(ifc.rsp_valid), 32'(tbl[i].rv));
      check($sformatf("t%0d_rsp_data", i), ifc.rsp_data, tbl[i].d);
      check($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("t%0d_flush_done", i), 32'(flush_done), 32'(tbl[i].done));
    end
    // all requesters streaming from reset: strict rotation, responses 4 cycles behind
    drive(1'b1, 1'b0, 4'b0000, OP_ADD, Z, Z);
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, 4'b1111, OP_ADD, ONE, ONE);
      check("stream_ready", 32'(ifc.req_ready), 32'(1 << (k % 4)));
      check("stream_rsp", 32'(ifc.rsp_valid), k >= 4 ? 32'(1 << ((k - 4) % 4)) : 32'h0);
    end
    // flush with three ops in flight while everyone keeps requesting
    drive(1'b1, 1'b0, 4'b0000, OP_ADD, Z, Z);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 4'b1111, OP_MUL, TWO, TWO);
    npulse = 0;
    nrsp   = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, k == 0, 4'b1111, OP_MUL, TWO, TWO);
      check("flush_ready", 32'(ifc.req_ready), 32'h0);
      check("flush_done_at", 32'(flush_done), 32'(k == 4));
      npulse += int'(flush_done);
      nrsp   += $countones(ifc.rsp_valid);
    end
    check("flush_pulses", npulse, 32'd1);
    check("flush_rsps", nrsp, 32'd3);
    drive(1'b0, 1'b0, 4'b1111, OP_MUL, TWO, TWO);
    check("after_flush_ready", 32'(ifc.req_ready), 32'b1000);
    // reset mid-flight: the two ops are discarded and the pointer restarts at req0
    drive(1'b1, 1'b0, 4'b0000, OP_ADD, Z, Z);
    drive(1'b0, 1'b0, 4'b0011, OP_ADD, ONE, ONE);
    drive(1'b0, 1'b0, 4'b0011, OP_ADD, ONE, ONE);
    drive(1'b1, 1'b0, 4'b0000, OP_ADD, Z, Z);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 4'b0000, OP_ADD, Z, Z);
      check("rst_no_rsp", 32'(ifc.rsp_valid), 32'h0);
    end
    drive(1'b0, 1'b0, 4'b1111, OP_ADD, ONE, ONE);
    check("rst_ptr", 32'(ifc.req_ready), 32'b0001);
    // randomized traffic, checked every cycle by the reference model
    drive(1'b1, 1'b0, 4'b0000, OP_ADD, Z, Z);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      rst_n         = $urandom_range(0, 199) == 0;
      flush         = $urandom_range(0, 39) == 0;
      ifc.req_valid = 4'($urandom);
      for (int r = 0; r < N; r++) begin
        ifc.req_op[2*r +: 2] = 2'($urandom);
        ifc.req_a[32*r +: 32] = pool[$urandom_range(0, 5)];
        ifc.req_b[32*r +: 32] = pool[$urandom_range(0, 4)];
      end
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
